// File: rtl/pixel_readout_pkg.sv
// Shared types, default geometry and derived-constant helpers for the pixel readout collector.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pixel_readout_pkg;

    localparam int DEF_WIDTH      = 2;
    localparam int DEF_HEIGHT     = 2;
    localparam int DEF_OBPW       = 2;
    localparam int DEF_BIT_DEPTH  = 10;
    localparam int DEF_FIFO_DEPTH = 8;

    // State names the phase of the most recently consumed read sample.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW_SEL,
        ST_SETTLE,
        ST_BEAT,
        ST_DONE
    } rd_state_e;

    // Frame markers carried by every buffered beat entry; the geometry-sized
    // fields (lanes, row, beat) are wrapped around this in the top level.
    typedef struct packed {
        logic first;
        logic last;
    } beat_marks_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int beats_per_row(input int width, input int obpw);
        return width / obpw;
    endfunction

    function automatic int row_cycles(input int width, input int obpw);
        return 2 + beats_per_row(width, obpw);
    endfunction

    function automatic int read_cycles(input int width, input int height, input int obpw);
        return height * row_cycles(width, obpw) + 1;
    endfunction

    localparam int BEATS_PER_ROW = beats_per_row(DEF_WIDTH, DEF_OBPW);
    localparam int ROW_CYCLES    = row_cycles(DEF_WIDTH, DEF_OBPW);
    localparam int READ_CYCLES   = read_cycles(DEF_WIDTH, DEF_HEIGHT, DEF_OBPW);
    localparam int ROW_IDX_W     = idx_w(DEF_HEIGHT);
    localparam int COL_IDX_W     = idx_w(DEF_WIDTH);

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pixel_readout_fifo.sv
// Synchronous FIFO for beat entries; ports: clk/rst, push/push_data, pop, head/empty/full.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: push is ignored while full unless the head pops in the same cycle.
module pixel_readout_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic          full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pixel_readout_collector.sv
// Samples pixel-array bus beats during the READ_CLK_IN window and serialises them into a pixel stream.
// Latency: beat sampled at posedge t shows PIX_VALID after posedge t+1 (empty FIFO); 1 pixel/cycle drain.
// Backpressure: PIX_READY stalls the serialiser; a full FIFO drops the incoming beat and sets OVERFLOW.
// Ports: SYSTEM_CLK/SYSTEM_RESET, READ_CLK_IN + DATA_BUS in; PIX_VALID/READY/DATA/ROW/COL,
// FRAME_START/END, sticky OVERFLOW/TRUNCATED, FRAME_COUNT out.
// Build option: define PIXEL_READOUT_GRAY_DECODE_EN to Gray-decode each lane on the way to PIX_DATA.
module pixel_readout_collector
    import pixel_readout_pkg::*;
#(
    parameter int WIDTH                  = DEF_WIDTH,
    parameter int HEIGHT                 = DEF_HEIGHT,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = DEF_OBPW,
    parameter int BIT_DEPTH              = DEF_BIT_DEPTH,
    parameter int FIFO_DEPTH             = DEF_FIFO_DEPTH
) (
    input  logic                                        SYSTEM_CLK,
    input  logic                                        SYSTEM_RESET,
    input  logic                                        READ_CLK_IN,
    input  logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] DATA_BUS,
    output logic                                        PIX_VALID,
    input  logic                                        PIX_READY,
    output logic [BIT_DEPTH-1:0]                        PIX_DATA,
    output logic [idx_w(HEIGHT)-1:0]                    PIX_ROW,
    output logic [idx_w(WIDTH)-1:0]                     PIX_COL,
    output logic                                        FRAME_START,
    output logic                                        FRAME_END,
    output logic                                        OVERFLOW,
    output logic                                        TRUNCATED,
    output logic [15:0]                                 FRAME_COUNT
);

    localparam int OBPW   = OUTPUT_BUS_PIXEL_WIDTH;
    localparam int BEATS  = beats_per_row(WIDTH, OBPW);
    localparam int ROW_W  = idx_w(HEIGHT);
    localparam int COL_W  = idx_w(WIDTH);
    localparam int BEAT_W = idx_w(BEATS);
    localparam int LANE_W = idx_w(OBPW);

    typedef struct packed {
        logic [OBPW*BIT_DEPTH-1:0] lanes;
        logic [ROW_W-1:0]          row;
        logic [BEAT_W-1:0]         beat;
        beat_marks_t               marks;
    } entry_t;

    rd_state_e         state, state_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt, smp_beat;
    logic              smp_vld, trunc_set;
    entry_t            smp_entry, cap_entry, head;
    logic              cap_vld;
    logic              fifo_empty, fifo_full, pop;
    logic [LANE_W-1:0] lane_idx;
    logic              hs, last_lane;
    logic [BIT_DEPTH-1:0] lane_raw, lane_out;

    // Window sequencer: row counter and last-written beat track sample index k.
    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state <= ST_IDLE;
            row   <= '0;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            beat  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        beat_nxt  = beat;
        smp_vld   = 1'b0;
        smp_beat  = beat;
        trunc_set = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (READ_CLK_IN) begin
                    state_nxt = ST_ROW_SEL;
                    row_nxt   = '0;
                end
            end
            ST_ROW_SEL: begin
                if (!READ_CLK_IN) begin
                    state_nxt = ST_IDLE;
                    trunc_set = 1'b1;
                end else begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!READ_CLK_IN) begin
                    state_nxt = ST_IDLE;
                    trunc_set = 1'b1;
                end else begin
                    state_nxt = ST_BEAT;
                    beat_nxt  = '0;
                    smp_beat  = '0;
                    smp_vld   = 1'b1;
                end
            end
            ST_BEAT: begin
                if (!READ_CLK_IN) begin
                    state_nxt = ST_IDLE;
                    trunc_set = 1'b1;
                end else if (beat != BEAT_W'(BEATS - 1)) begin
                    beat_nxt = beat + BEAT_W'(1);
                    smp_beat = beat + BEAT_W'(1);
                    smp_vld  = 1'b1;
                end else if (row != ROW_W'(HEIGHT - 1)) begin
                    // This sample is the next row's select cycle.
                    state_nxt = ST_ROW_SEL;
                    row_nxt   = row + ROW_W'(1);
                end else begin
                    // Trailing cycle of the window.
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!READ_CLK_IN) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        smp_entry             = '0;
        smp_entry.lanes       = DATA_BUS;
        smp_entry.row         = row;
        smp_entry.beat        = smp_beat;
        smp_entry.marks.first = (row == '0) && (smp_beat == '0);
        smp_entry.marks.last  = (row == ROW_W'(HEIGHT - 1)) && (smp_beat == BEAT_W'(BEATS - 1));
    end

    // Capture stage, then FIFO; sticky status and serialiser lane pointer.
    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            cap_vld     <= 1'b0;
            cap_entry   <= '0;
            OVERFLOW    <= 1'b0;
            TRUNCATED   <= 1'b0;
            lane_idx    <= '0;
            FRAME_COUNT <= '0;
        end else begin
            cap_vld <= smp_vld;
            if (smp_vld) cap_entry <= smp_entry;
            if (cap_vld && fifo_full && !pop) OVERFLOW <= 1'b1;
            if (trunc_set) TRUNCATED <= 1'b1;
            if (hs) lane_idx <= last_lane ? '0 : lane_idx + LANE_W'(1);
            if (hs && FRAME_END) FRAME_COUNT <= FRAME_COUNT + 16'd1;
        end
    end

    pixel_readout_fifo #(
        .DW    ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (SYSTEM_CLK),
        .rst       (SYSTEM_RESET),
        .push      (cap_vld),
        .push_data (cap_entry),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign PIX_VALID = !fifo_empty;
    assign hs        = PIX_VALID && PIX_READY;
    assign last_lane = (lane_idx == LANE_W'(OBPW - 1));
    assign pop       = hs && last_lane;
    assign lane_raw  = head.lanes[lane_idx*BIT_DEPTH +: BIT_DEPTH];

`ifdef PIXEL_READOUT_GRAY_DECODE_EN
    assign lane_out = BIT_DEPTH'(gray2bin(32'(lane_raw)));
`else
    assign lane_out = lane_raw;
`endif

    // Head memory is unreset; outputs are masked so nothing leaks while idle.
    assign PIX_DATA    = PIX_VALID ? lane_out : '0;
    assign PIX_ROW     = PIX_VALID ? head.row : '0;
    assign PIX_COL     = PIX_VALID ? COL_W'(int'(head.beat) * OBPW + int'(lane_idx)) : '0;
    assign FRAME_START = PIX_VALID && (lane_idx == '0) && head.marks.first;
    assign FRAME_END   = PIX_VALID && last_lane && head.marks.last;

endmodule

// File: tb/tb_pixel_readout_collector.sv
module tb_pixel_readout_collector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default-geometry instance
    logic        a_read = 1'b0;
    logic [19:0] a_bus  = '0;
    logic        a_rdy  = 1'b0;
    logic        a_vld, a_row, a_col, a_fs, a_fe, a_ov, a_tr;
    logic [9:0]  a_data;
    logic [15:0] a_fc;

    // HEIGHT=4, FIFO_DEPTH=2 instance
    logic        b_read = 1'b0;
    logic [19:0] b_bus  = '0;
    logic        b_rdy  = 1'b0;
    logic        b_vld, b_col, b_fs, b_fe, b_ov, b_tr;
    logic [1:0]  b_row;
    logic [9:0]  b_data;
    logic [15:0] b_fc;

    pixel_readout_collector dut_a (
        .SYSTEM_CLK(clk), .SYSTEM_RESET(rst), .READ_CLK_IN(a_read), .DATA_BUS(a_bus),
        .PIX_VALID(a_vld), .PIX_READY(a_rdy), .PIX_DATA(a_data), .PIX_ROW(a_row), .PIX_COL(a_col),
        .FRAME_START(a_fs), .FRAME_END(a_fe), .OVERFLOW(a_ov), .TRUNCATED(a_tr), .FRAME_COUNT(a_fc)
    );

    pixel_readout_collector #(.HEIGHT(4), .FIFO_DEPTH(2)) dut_b (
        .SYSTEM_CLK(clk), .SYSTEM_RESET(rst), .READ_CLK_IN(b_read), .DATA_BUS(b_bus),
        .PIX_VALID(b_vld), .PIX_READY(b_rdy), .PIX_DATA(b_data), .PIX_ROW(b_row), .PIX_COL(b_col),
        .FRAME_START(b_fs), .FRAME_END(b_fe), .OVERFLOW(b_ov), .TRUNCATED(b_tr), .FRAME_COUNT(b_fc)
    );

    typedef struct packed {
        logic [9:0] data;
        logic [1:0] row;
        logic       col;
        logic       fs;
        logic       fe;
    } pix_t;

    pix_t        sbq[$];
    logic [9:0]  fv [8];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_fc      = '0;
    logic        exp_tr      = 1'b0;

    function automatic logic [9:0] expect_data(input logic [9:0] raw);
        logic [9:0] v;
        v = raw;
`ifdef PIXEL_READOUT_GRAY_DECODE_EN
        for (int s = 1; s < 10; s++) v = v ^ (raw >> s);
`endif
        return v;
    endfunction

    // Drives nfr windows (one idle cycle between), reading up to sample last_k,
    // and scores every accepted pixel on dut_a against the queue.
    task automatic run_frame_a(input int nfr, input int last_k, input bit rand_rdy);
        int   c = 0;
        int   f, k, r;
        bit   done = 0;
        pix_t exp_p, got;
        while (!done) begin
            @(negedge clk);
            a_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            f = c / 8;
            k = c % 8;
            if (f < nfr && k < 7 && k <= last_k) begin
                a_read = 1'b1;
                if (k == 2 || k == 5) begin
                    r = (k == 5) ? 1 : 0;
                    a_bus = {fv[f*4+2*r+1], fv[f*4+2*r]};
                    sbq.push_back('{data: expect_data(fv[f*4+2*r]), row: 2'(r), col: 1'b0,
                                    fs: (r == 0), fe: 1'b0});
                    sbq.push_back('{data: expect_data(fv[f*4+2*r+1]), row: 2'(r), col: 1'b1,
                                    fs: 1'b0, fe: (r == 1)});
                end else begin
                    a_bus = '0;
                end
            end else begin
                a_read = 1'b0;
                a_bus  = '0;
            end
            if (nfr == 1 && last_k >= 2 && (c == 3 || c == 4)) begin
                vectors++;
                if (a_vld !== (c == 4)) begin
                    miscompares++;
                    $display("FAIL latency c=%0d: PIX_VALID got %b expected %b", c, a_vld, (c == 4));
                end
            end
            if (a_vld && a_rdy) begin
                got = '{data: a_data, row: {1'b0, a_row}, col: a_col, fs: a_fs, fe: a_fe};
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_pixel: got %h expected none", got);
                end else begin
                    exp_p = sbq.pop_front();
                    if (got !== exp_p) begin
                        miscompares++;
                        $display("FAIL pixel: got data=%h row=%0d col=%0d fs=%b fe=%b expected data=%h row=%0d col=%0d fs=%b fe=%b",
                                 got.data, got.row, got.col, got.fs, got.fe,
                                 exp_p.data, exp_p.row, exp_p.col, exp_p.fs, exp_p.fe);
                    end
                end
            end
            c++;
            if (c >= 8 * nfr && sbq.size() == 0 && !a_vld) done = 1;
            if (!done && c > 8 * nfr + 100) begin
                vectors++;
                miscompares++;
                $display("FAIL drain_timeout: %0d pixels outstanding, expected 0", sbq.size());
                sbq.delete();
                done = 1;
            end
        end
        if (last_k >= 6) exp_fc = exp_fc + 16'(nfr);
        else             exp_tr = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({a_vld, a_fc, a_tr, a_ov} !== {1'b0, exp_fc, exp_tr, 1'b0}) begin
            miscompares++;
            $display("FAIL frame_status: got vld=%b fc=%0d tr=%b ov=%b expected vld=0 fc=%0d tr=%b ov=0",
                     a_vld, a_fc, a_tr, a_ov, exp_fc, exp_tr);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({a_vld, a_data, a_row, a_col, a_fs, a_fe, a_ov, a_tr, a_fc} !== '0) begin
            miscompares++;
            $display("FAIL reset_a: got vld=%b data=%h fs=%b fe=%b ov=%b tr=%b fc=%0d expected all 0",
                     a_vld, a_data, a_fs, a_fe, a_ov, a_tr, a_fc);
        end
        vectors++;
        if ({b_vld, b_data, b_row, b_col, b_fs, b_fe, b_ov, b_tr, b_fc} !== '0) begin
            miscompares++;
            $display("FAIL reset_b: got vld=%b data=%h fs=%b fe=%b ov=%b tr=%b fc=%0d expected all 0",
                     b_vld, b_data, b_fs, b_fe, b_ov, b_tr, b_fc);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame;
        fv[0] = 10'h001; fv[1] = 10'h002; fv[2] = 10'h003; fv[3] = 10'h004;
        run_frame_a(1, 6, 1'b0);
    endtask

    task automatic test_gray_decode;
        fv[0] = 10'h003; fv[1] = 10'h006; fv[2] = 10'h2A5; fv[3] = 10'h3FF;
        run_frame_a(1, 6, 1'b0);
    endtask

    task automatic test_truncated;
        fv[0] = 10'h011; fv[1] = 10'h022; fv[2] = 10'h033; fv[3] = 10'h044;
        run_frame_a(1, 3, 1'b0);
    endtask

    task automatic test_overflow;
        pix_t exp_p, got;
        int   r;
        b_rdy = 1'b0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            b_read = 1'b1;
            if (c % 3 == 2) begin
                r = c / 3;
                b_bus = {10'(16 * r + 2), 10'(16 * r + 1)};
                if (r < 2) begin
                    sbq.push_back('{data: expect_data(10'(16 * r + 1)), row: 2'(r), col: 1'b0,
                                    fs: (r == 0), fe: 1'b0});
                    sbq.push_back('{data: expect_data(10'(16 * r + 2)), row: 2'(r), col: 1'b1,
                                    fs: 1'b0, fe: 1'b0});
                end
            end else begin
                b_bus = '0;
            end
            if (c == 9) begin
                vectors++;
                if (b_ov !== 1'b0) begin
                    miscompares++;
                    $display("FAIL overflow_early: got %b expected 0", b_ov);
                end
            end
        end
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            b_read = 1'b0;
            b_bus  = '0;
            got = '{data: b_data, row: b_row, col: b_col, fs: b_fs, fe: b_fe};
            vectors++;
            if (!b_vld || got !== sbq[0]) begin
                miscompares++;
                $display("FAIL stall_hold: got vld=%b pix=%h expected vld=1 pix=%h", b_vld, got, sbq[0]);
            end
        end
        vectors++;
        if ({b_ov, b_tr} !== 2'b10) begin
            miscompares++;
            $display("FAIL overflow_flags: got ov=%b tr=%b expected ov=1 tr=0", b_ov, b_tr);
        end
        for (int c = 0; c < 40 && (sbq.size() != 0 || b_vld); c++) begin
            @(negedge clk);
            b_rdy = 1'b1;
            if (b_vld) begin
                got = '{data: b_data, row: b_row, col: b_col, fs: b_fs, fe: b_fe};
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL overflow_extra: got %h expected none", got);
                end else begin
                    exp_p = sbq.pop_front();
                    if (got !== exp_p) begin
                        miscompares++;
                        $display("FAIL overflow_pixel: got %h expected %h", got, exp_p);
                    end
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (sbq.size() != 0 || b_vld !== 1'b0 || b_fc !== 16'd0) begin
            miscompares++;
            $display("FAIL overflow_drain: got left=%0d vld=%b fc=%0d expected left=0 vld=0 fc=0",
                     sbq.size(), b_vld, b_fc);
        end
        sbq.delete();
        b_rdy = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            a_rdy  = 1'b1;
            a_read = (c < 5);
            a_bus  = (c == 2) ? {10'h0AA, 10'h055} : 20'h0;
            if (c == 4) begin
                vectors++;
                if ({a_vld, a_data, a_fs} !== {1'b1, expect_data(10'h055), 1'b1}) begin
                    miscompares++;
                    $display("FAIL midframe_first: got vld=%b data=%h fs=%b expected vld=1 data=%h fs=1",
                             a_vld, a_data, a_fs, expect_data(10'h055));
                end
            end
            if (c == 5) rst = 1'b1;
        end
        @(negedge clk);
        vectors++;
        if ({a_vld, a_data, a_row, a_col, a_fs, a_fe, a_ov, a_tr, a_fc} !== '0) begin
            miscompares++;
            $display("FAIL midframe_reset: got vld=%b data=%h ov=%b tr=%b fc=%0d expected all 0",
                     a_vld, a_data, a_ov, a_tr, a_fc);
        end
        rst    = 1'b0;
        exp_fc = '0;
        exp_tr = 1'b0;
        repeat (2) @(negedge clk);
        fv[0] = 10'h101; fv[1] = 10'h102; fv[2] = 10'h103; fv[3] = 10'h104;
        run_frame_a(1, 6, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) fv[i] = 10'($urandom_range(0, 1023));
        run_frame_a(2, 6, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_gray_decode();
        test_truncated();
        test_overflow();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
